// File: rtl/z80fi_insn_collector_if.sv
// CPU-side trace inputs and the retired-instruction (z80fi) packet of the collector.
// The collector connects through the slave modport; a CPU model or bench drives through master.
interface z80fi_insn_collector_if;
  logic        insn_start;
  logic        fetch_valid;
  logic [7:0]  fetch_data;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_valid;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        insn_done;
  logic [15:0] cpu_ip;
  logic [15:0] cpu_hl;

  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic        z80fi_mem_rd;
  logic [15:0] z80fi_mem_raddr;
  logic [7:0]  z80fi_mem_rdata;
  logic        z80fi_mem_wr;
  logic [15:0] z80fi_mem_waddr;
  logic [7:0]  z80fi_mem_wdata;
  logic [15:0] z80fi_reg_ip_in;
  logic [15:0] z80fi_reg_ip_out;
  logic [15:0] z80fi_reg_hl_in;
  logic        z80fi_err;

  modport master (
    output insn_start, fetch_valid, fetch_data,
    output mem_rd_valid, mem_rd_addr, mem_rd_data,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    output insn_done, cpu_ip, cpu_hl,
    input  z80fi_valid, z80fi_insn, z80fi_insn_len,
    input  z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata,
    input  z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata,
    input  z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_hl_in, z80fi_err
  );

  modport slave (
    input  insn_start, fetch_valid, fetch_data,
    input  mem_rd_valid, mem_rd_addr, mem_rd_data,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  insn_done, cpu_ip, cpu_hl,
    output z80fi_valid, z80fi_insn, z80fi_insn_len,
    output z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata,
    output z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata,
    output z80fi_reg_ip_in, z80fi_reg_ip_out, z80fi_reg_hl_in, z80fi_err
  );
endinterface

// File: rtl/z80fi_insn_collector.sv
// Gathers the fetch bytes, one data read, one data write and IP/HL snapshots of a Z80
// instruction and emits them as a single registered z80fi packet when it retires.
module z80fi_insn_collector (
  input  logic                          clk,
  input  logic                          reset,
  z80fi_insn_collector_if.slave         bus
);

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [2:0]  len;
    logic        rd;
    logic [15:0] raddr;
    logic [7:0]  rdata;
    logic        wr;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] ip_in;
    logic [15:0] hl_in;
    logic        err;
  } work_t;

  state_t      r_state, w_state_nxt;
  work_t       r_work, w_cur, w_nxt;
  work_t       r_pkt;
  logic [15:0] r_ip_out;
  logic        r_valid;
  logic        w_collect, w_retire, w_fetch, w_rd, w_wr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.insn_start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (!bus.insn_start && bus.insn_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // A fetch alongside insn_start is byte 0 of the new instruction, never the tail of the old one.
  always_comb begin
    w_collect = (r_state == S_COLLECT);
    w_retire  = w_collect && bus.insn_done;
    w_fetch   = w_collect && bus.fetch_valid && !bus.insn_start;
    w_rd      = w_collect && bus.mem_rd_valid;
    w_wr      = w_collect && bus.mem_wr_valid;
  end

  // w_cur: working state including this cycle's events; it is what a retiring packet carries.
  always_comb begin
    w_cur = r_work;
    if (w_fetch) begin
      if (r_work.len == 3'd4) begin
        w_cur.err = 1'b1;
      end else begin
        w_cur.insn[{r_work.len[1:0], 3'b000} +: 8] = bus.fetch_data;
        w_cur.len = r_work.len + 3'd1;
      end
    end
    if (w_rd) begin
      if (r_work.rd) begin
        w_cur.err = 1'b1;
      end else begin
        w_cur.rd    = 1'b1;
        w_cur.raddr = bus.mem_rd_addr;
        w_cur.rdata = bus.mem_rd_data;
      end
    end
    if (w_wr) begin
      if (r_work.wr) begin
        w_cur.err = 1'b1;
      end else begin
        w_cur.wr    = 1'b1;
        w_cur.waddr = bus.mem_wr_addr;
        w_cur.wdata = bus.mem_wr_data;
      end
    end
  end

  // Restart without retirement abandons the old instruction and flags the next packet.
  always_comb begin
    w_nxt = w_cur;
    if (bus.insn_start) begin
      w_nxt       = '0;
      w_nxt.ip_in = bus.cpu_ip;
      w_nxt.hl_in = bus.cpu_hl;
      if (bus.fetch_valid) begin
        w_nxt.insn[7:0] = bus.fetch_data;
        w_nxt.len       = 3'd1;
      end
      w_nxt.err = w_collect && !bus.insn_done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work   <= '0;
      r_pkt    <= '0;
      r_ip_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_work  <= w_nxt;
      r_valid <= w_retire;
      if (w_retire) begin
        r_pkt    <= w_cur;
        r_ip_out <= bus.cpu_ip;
      end
    end
  end

  assign bus.z80fi_valid      = r_valid;
  assign bus.z80fi_insn       = r_pkt.insn;
  assign bus.z80fi_insn_len   = r_pkt.len;
  assign bus.z80fi_mem_rd     = r_pkt.rd;
  assign bus.z80fi_mem_raddr  = r_pkt.raddr;
  assign bus.z80fi_mem_rdata  = r_pkt.rdata;
  assign bus.z80fi_mem_wr     = r_pkt.wr;
  assign bus.z80fi_mem_waddr  = r_pkt.waddr;
  assign bus.z80fi_mem_wdata  = r_pkt.wdata;
  assign bus.z80fi_reg_ip_in  = r_pkt.ip_in;
  assign bus.z80fi_reg_ip_out = r_ip_out;
  assign bus.z80fi_reg_hl_in  = r_pkt.hl_in;
  assign bus.z80fi_err        = r_pkt.err;

endmodule

// File: tb/tb_z80fi_insn_collector.sv
// Directed and random stimulus for the z80fi collector against a queue-based instruction model.
module tb_z80fi_insn_collector;

  logic clk;
  logic reset;
  z80fi_insn_collector_if bus ();

  z80fi_insn_collector dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] insn;
    logic [2:0]  len;
    logic        rd;
    logic [15:0] raddr;
    logic [7:0]  rdata;
    logic        wr;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [15:0] ip_in;
    logic [15:0] ip_out;
    logic [15:0] hl_in;
    logic        err;
  } pkt_t;

  int n_tot = 0;
  int n_bad = 0;

  // stimulus for the next cycle; ip/hl persist as live CPU registers
  logic        c_start, c_fv, c_rv, c_wv, c_done;
  logic [7:0]  c_fd, c_rd, c_wd;
  logic [15:0] c_ra, c_wa, c_ip, c_hl;

  // model: the instruction in flight as plain lists of events
  bit          m_active;
  logic [7:0]  m_bytes[$];
  logic [23:0] m_rds[$];
  logic [23:0] m_wrs[$];
  bit          m_abandon;
  logic [15:0] m_ip_in, m_hl_in;
  pkt_t        e;
  logic        e_valid;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_pkt();
    chk("valid",  32'(bus.z80fi_valid),      32'(e_valid));
    chk("insn",   bus.z80fi_insn,            e.insn);
    chk("len",    32'(bus.z80fi_insn_len),   32'(e.len));
    chk("rd",     32'(bus.z80fi_mem_rd),     32'(e.rd));
    chk("raddr",  32'(bus.z80fi_mem_raddr),  32'(e.raddr));
    chk("rdata",  32'(bus.z80fi_mem_rdata),  32'(e.rdata));
    chk("wr",     32'(bus.z80fi_mem_wr),     32'(e.wr));
    chk("waddr",  32'(bus.z80fi_mem_waddr),  32'(e.waddr));
    chk("wdata",  32'(bus.z80fi_mem_wdata),  32'(e.wdata));
    chk("ip_in",  32'(bus.z80fi_reg_ip_in),  32'(e.ip_in));
    chk("ip_out", 32'(bus.z80fi_reg_ip_out), 32'(e.ip_out));
    chk("hl_in",  32'(bus.z80fi_reg_hl_in),  32'(e.hl_in));
    chk("err",    32'(bus.z80fi_err),        32'(e.err));
  endtask

  task automatic model_step();
    bit abandon;
    abandon = 0;
    e_valid = 1'b0;
    if (m_active) begin
      if (c_fv && !c_start) m_bytes.push_back(c_fd);
      if (c_rv) m_rds.push_back({c_ra, c_rd});
      if (c_wv) m_wrs.push_back({c_wa, c_wd});
      if (c_done) begin
        e_valid = 1'b1;
        e = '0;
        for (int k = 0; k < 4 && k < m_bytes.size(); k++) e.insn[8*k +: 8] = m_bytes[k];
        e.len = (m_bytes.size() > 4) ? 3'd4 : 3'(m_bytes.size());
        if (m_rds.size() > 0) begin e.rd = 1'b1; {e.raddr, e.rdata} = m_rds[0]; end
        if (m_wrs.size() > 0) begin e.wr = 1'b1; {e.waddr, e.wdata} = m_wrs[0]; end
        e.ip_in  = m_ip_in;
        e.ip_out = c_ip;
        e.hl_in  = m_hl_in;
        e.err    = m_abandon || m_bytes.size() > 4 || m_rds.size() > 1 || m_wrs.size() > 1;
      end else if (c_start) begin
        abandon = 1;
      end
    end
    if (c_start) begin
      m_active = 1;
      m_bytes.delete();
      m_rds.delete();
      m_wrs.delete();
      if (c_fv) m_bytes.push_back(c_fd);
      m_abandon = abandon;
      m_ip_in   = c_ip;
      m_hl_in   = c_hl;
    end else if (m_active && c_done) begin
      m_active = 0;
    end
  endtask

  task automatic clear_in();
    c_start = 0; c_fv = 0; c_rv = 0; c_wv = 0; c_done = 0;
    c_fd = '0; c_rd = '0; c_wd = '0; c_ra = '0; c_wa = '0;
  endtask

  task automatic step();
    bus.insn_start   = c_start;
    bus.fetch_valid  = c_fv;
    bus.fetch_data   = c_fd;
    bus.mem_rd_valid = c_rv;
    bus.mem_rd_addr  = c_ra;
    bus.mem_rd_data  = c_rd;
    bus.mem_wr_valid = c_wv;
    bus.mem_wr_addr  = c_wa;
    bus.mem_wr_data  = c_wd;
    bus.insn_done    = c_done;
    bus.cpu_ip       = c_ip;
    bus.cpu_hl       = c_hl;
    model_step();
    @(posedge clk);
    #1;
    check_pkt();
    clear_in();
  endtask

  // reset raised between edges; outputs must clear before any clock edge
  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_active = 0;
    m_bytes.delete(); m_rds.delete(); m_wrs.delete();
    e = '0;
    e_valid = 1'b0;
    check_pkt();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_ip = '0; c_hl = '0;
    clear_in();
    m_active = 0; m_abandon = 0; m_ip_in = '0; m_hl_in = '0;
    e = '0; e_valid = 1'b0;
    do_reset();

    // SET 3,(HL)
    c_ip = 16'h0100; c_hl = 16'h4000;
    c_start = 1; c_fv = 1; c_fd = 8'hCB; step();
    c_fv = 1; c_fd = 8'hDE; step();
    c_rv = 1; c_ra = 16'h4000; c_rd = 8'h01; step();
    c_wv = 1; c_wa = 16'h4000; c_wd = 8'h09; step();
    c_ip = 16'h0102; c_done = 1; step();
    chk("set3_valid", 32'(bus.z80fi_valid), 32'd1);
    chk("set3_insn", bus.z80fi_insn, 32'h0000DECB);
    chk("set3_len", 32'(bus.z80fi_insn_len), 32'd2);
    chk("set3_rdata", 32'(bus.z80fi_mem_rdata), 32'h01);
    chk("set3_wdata", 32'(bus.z80fi_mem_wdata), 32'h09);
    chk("set3_ipout", 32'(bus.z80fi_reg_ip_out), 32'h0102);
    chk("set3_err", 32'(bus.z80fi_err), 32'd0);
    step();
    chk("set3_pulse", 32'(bus.z80fi_valid), 32'd0);

    // back-to-back: LD A,55 retires while NOP starts
    c_ip = 16'h0200;
    c_start = 1; c_fv = 1; c_fd = 8'h3E; step();
    c_fv = 1; c_fd = 8'h55; step();
    c_ip = 16'h0202; c_done = 1; c_start = 1; c_fv = 1; c_fd = 8'h00; step();
    chk("b2b_first", bus.z80fi_insn, 32'h0000553E);
    c_ip = 16'h0203; c_done = 1; step();
    chk("b2b_valid2", 32'(bus.z80fi_valid), 32'd1);
    chk("b2b_insn2", bus.z80fi_insn, 32'h0);
    chk("b2b_len2", 32'(bus.z80fi_insn_len), 32'd1);
    chk("b2b_rdwr2", {30'd0, bus.z80fi_mem_rd, bus.z80fi_mem_wr}, 32'd0);

    // five fetch bytes overflow the buffer
    c_start = 1; c_fv = 1; c_fd = 8'hDD; step();
    c_fv = 1; c_fd = 8'hCB; step();
    c_fv = 1; c_fd = 8'h05; step();
    c_fv = 1; c_fd = 8'hC6; step();
    c_fv = 1; c_fd = 8'hAA; step();
    c_done = 1; step();
    chk("ovf_insn", bus.z80fi_insn, 32'hC605CBDD);
    chk("ovf_len", 32'(bus.z80fi_insn_len), 32'd4);
    chk("ovf_err", 32'(bus.z80fi_err), 32'd1);

    // two data reads: first kept, second flagged
    c_start = 1; c_fv = 1; c_fd = 8'h7E; step();
    c_rv = 1; c_ra = 16'h1000; c_rd = 8'h11; step();
    c_rv = 1; c_ra = 16'h1001; c_rd = 8'h22; c_done = 1; step();
    chk("rd2_addr", 32'(bus.z80fi_mem_raddr), 32'h1000);
    chk("rd2_data", 32'(bus.z80fi_mem_rdata), 32'h11);
    chk("rd2_err", 32'(bus.z80fi_err), 32'd1);

    // insn_done while idle changes nothing
    c_done = 1; step();
    c_done = 1; step();
    chk("idle_done_valid", 32'(bus.z80fi_valid), 32'd0);
    chk("idle_done_raddr", 32'(bus.z80fi_mem_raddr), 32'h1000);

    // reset mid-instruction discards the partial packet
    c_start = 1; c_fv = 1; c_fd = 8'h12; step();
    c_fv = 1; c_fd = 8'h34; step();
    do_reset();
    c_done = 1; step();
    chk("rst_valid", 32'(bus.z80fi_valid), 32'd0);
    chk("rst_insn", bus.z80fi_insn, 32'd0);

    // abandoned instruction flags the next packet
    c_start = 1; c_fv = 1; c_fd = 8'h01; step();
    c_start = 1; c_fv = 1; c_fd = 8'h02; step();
    c_done = 1; step();
    chk("abandon_err", 32'(bus.z80fi_err), 32'd1);
    chk("abandon_insn", bus.z80fi_insn, 32'h02);

    for (int i = 0; i < 3000; i++) begin
      c_ip = 16'($urandom);
      c_hl = 16'($urandom);
      if (!m_active) begin
        c_start = ($urandom_range(0, 2) != 0);
        c_done  = ($urandom_range(0, 7) == 0);
      end else begin
        c_done  = ($urandom_range(0, 3) == 0);
        c_start = ($urandom_range(0, 11) == 0) || (c_done && $urandom_range(0, 2) == 0);
      end
      c_fv = ($urandom_range(0, 9) < 6);
      c_fd = 8'($urandom);
      c_rv = ($urandom_range(0, 6) == 0);
      c_ra = 16'($urandom);
      c_rd = 8'($urandom);
      c_wv = ($urandom_range(0, 6) == 0);
      c_wa = 16'($urandom);
      c_wd = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        clear_in();
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/z80fi_insn_collector.md
Z80FI_INSN_COLLECTOR -- requirements
Module: z80fi_insn_collector

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: insn_start  in  1  first opcode byte of a new instruction is being fetched (M1) this cycle.
REQ-004 SHALL provide: fetch_valid  in  1 / fetch_data  in  8  instruction byte fetched this cycle (opcode, prefix, displacement or immediate).
REQ-005 SHALL provide: mem_rd_valid  in  1 / mem_rd_addr  in  16 / mem_rd_data  in  8  non-fetch data read.
REQ-006 SHALL provide: mem_wr_valid  in  1 / mem_wr_addr  in  16 / mem_wr_data  in  8  data write.
REQ-007 SHALL provide: insn_done  in  1  last cycle of the current instruction.
REQ-008 SHALL provide: cpu_ip  in  16 / cpu_hl  in  16  live architectural IP and HL.
REQ-009 SHALL provide outputs: z80fi_valid 1, z80fi_insn 32, z80fi_insn_len 3, z80fi_mem_rd 1, z80fi_mem_raddr 16, z80fi_mem_rdata 8, z80fi_mem_wr 1, z80fi_mem_waddr 16, z80fi_mem_wdata 8, z80fi_reg_ip_in 16, z80fi_reg_ip_out 16, z80fi_reg_hl_in 16, z80fi_err 1; all registered.

Function
REQ-010 SHALL implement states IDLE and COLLECT; reset enters IDLE.
REQ-011 IDLE: insn_start -> COLLECT; other inputs ignored, including insn_done.
REQ-012 On insn_start, SHALL snapshot cpu_ip -> ip_in and cpu_hl -> hl_in, clear the working insn buffer to 0, set byte count 0, clear rd/wr/err working flags.
REQ-013 Byte k (0-based) of the instruction SHALL be stored at insn[8k+7:8k]; first byte (e.g. CB prefix) in [7:0]; unused bytes 0.
REQ-014 A fetch_valid in the same cycle as insn_start SHALL be stored as byte 0.
REQ-015 In COLLECT, each fetch_valid SHALL append one byte and increment count; a 5th or later byte SHALL be dropped, count held at 4, err set.
REQ-016 First mem_rd_valid per instruction SHALL capture addr/data and set rd; later reads SHALL be ignored and set err.
REQ-017 First mem_wr_valid per instruction SHALL capture addr/data and set wr; later writes SHALL be ignored and set err.
REQ-018 Fetch/read/write events in the insn_done cycle SHALL be included in the retiring packet.
REQ-019 insn_done in COLLECT SHALL capture cpu_ip as ip_out and, on the next rising edge, load all z80fi_* outputs from the working state and assert z80fi_valid for exactly one cycle.
REQ-020 Latency: z80fi_valid high in cycle N+1 when insn_done sampled in cycle N.
REQ-021 z80fi_* packet outputs other than z80fi_valid SHALL hold their values until the next packet load.
REQ-022 insn_done without insn_start in COLLECT -> IDLE; insn_done with insn_start same cycle -> packet emitted for current instruction and new collection started (REQ-012/014 applied) and state stays COLLECT.
REQ-023 insn_start in COLLECT without insn_done SHALL abandon the current instruction (no packet), set err for the next emitted packet, and restart collection.
REQ-024 z80fi_insn_len SHALL equal the stored byte count (0..4) at retirement.
REQ-025 z80fi_mem_rd/z80fi_mem_wr SHALL be 0 when no read/write occurred; corresponding addr/data outputs then 0.

Reset
REQ-026 reset asserted SHALL immediately force IDLE, z80fi_valid 0, and all z80fi_* outputs and working registers to 0, independent of clk.
REQ-027 reset mid-instruction SHALL discard the partial packet; no z80fi_valid until a full insn_start..insn_done sequence after release.
REQ-028 First rising edge after reset deassertion SHALL be able to accept insn_start.

Verification
REQ-029 SET 3,(HL): ip 0x0100, hl 0x4000; fetch CB,DE; read 0x4000=0x01; write 0x4000=0x09; insn_done with cpu_ip 0x0102 -> one-cycle valid, insn 0x0000DECB, len 2, rd 1 raddr 0x4000 rdata 0x01, wr 1 waddr 0x4000 wdata 0x09, ip_in 0x0100, ip_out 0x0102, hl_in 0x4000, err 0.
REQ-030 Back-to-back: insn_done and insn_start same cycle, second insn NOP (00) -> two packets in consecutive valid pulses; second has insn 0x00000000, len 1, rd 0, wr 0.
REQ-031 Overflow: five fetch bytes DD,CB,05,C6,AA -> insn 0xC605CBDD, len 4, err 1.
REQ-032 Two data reads (0x1000=0x11, 0x1001=0x22) -> raddr 0x1000, rdata 0x11, err 1.
REQ-033 reset pulsed after two bytes fetched, then insn_done -> no valid pulse; all outputs 0.
REQ-034 insn_done in IDLE -> no valid pulse, outputs unchanged.
